seq_divider: RTL

- Multi-cycle 64-bit restoring divider for the RISC-V M-extension (DIV, DIVU, REM, REMU) in the execute stage.
- Repeatedly applies the A + ~B + 1 subtraction used by the datapath's existing subtractor, one quotient bit per cycle.
- Sits beside the ALU; a start/done handshake stalls the pipeline while the divider is busy.

---
 rtl/seq_divider.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for RISC-V DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional build macro SEQ_DIV_EARLY_OUT_EN skips iteration when |dividend| < |divisor|.
module seq_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE     = XLEN'(1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q;
  logic [XLEN-1:0] rem_q, quo_q, divisor_q, result_q;
  logic [CW-1:0]   cnt_q;
  logic            negQuo_q, negRem_q, remSel_q;
  logic            busy_q, done_q, dbz_q;

  logic            signedOp, dividendNeg, divisorNeg, zeroDiv, overflow;
  logic [XLEN-1:0] absDividend, absDivisor;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] rem_d, quo_d, fixQuo, fixRem;

  // Operand conditioning in IDLE and one restoring step for CALC.
  always_comb begin
    signedOp    = ~op[0];
    dividendNeg = signedOp & dividend[XLEN-1];
    divisorNeg  = signedOp & divisor[XLEN-1];
    absDividend = dividendNeg ? (~dividend + ONE) : dividend;
    absDivisor  = divisorNeg  ? (~divisor  + ONE) : divisor;
    zeroDiv     = (divisor == '0);
    overflow    = signedOp && (dividend == MIN_NEG) && (divisor == '1);

    // rem < divisor keeps rem - divisor inside XLEN+1 signed range, so the top bit is the borrow.
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted + ~{1'b0, divisor_q} + (XLEN+1)'(1);
    rem_d   = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    quo_d   = {quo_q[XLEN-2:0], ~trial[XLEN]};

    fixQuo = negQuo_q ? (~quo_q + ONE) : quo_q;
    fixRem = negRem_q ? (~rem_q + ONE) : rem_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      negQuo_q  <= 1'b0;
      negRem_q  <= 1'b0;
      remSel_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            remSel_q  <= op[1];
            negQuo_q  <= dividendNeg ^ divisorNeg;
            negRem_q  <= dividendNeg;
            divisor_q <= absDivisor;
            busy_q    <= 1'b1;
            if (zeroDiv) begin
              result_q <= op[1] ? dividend : '1;
              dbz_q    <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else if (overflow) begin
              result_q <= op[1] ? '0 : dividend;
              dbz_q    <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
`ifdef SEQ_DIV_EARLY_OUT_EN
            end else if (absDividend < absDivisor) begin
              quo_q   <= '0;
              rem_q   <= absDividend;
              state_q <= FIX;
`endif
            end else begin
              quo_q   <= absDividend;
              rem_q   <= '0;
              cnt_q   <= CW'(XLEN - 1);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= remSel_q ? fixRem : fixQuo;
          dbz_q    <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule
